fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly downstream of the PC register: takes the current 20-bit `pc`, issues word reads to instruction memory over a request/grant/response handshake, and buffers returned instructions in a 2-entry queue for decode. It also drives the PC register's `inpc` input, so it alone decides whether the PC advances, holds (stall), or jumps (branch redirect). The PC register has no enable, so holding is done by feeding `pc` back on `inpc`.

## Interface
- `AW`, 20: instruction address width; must match the PC register.
- `DW`, 32: instruction word width.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc`  in  AW  current PC from the PC register.
- `inpc`  out  AW  next PC to the PC register.
- `br_taken`  in  1  redirect request from execute, single-cycle pulse.
- `br_target`  in  AW  redirect address, valid with `br_taken`.
- `mem_req`  out  1  fetch request.
- `mem_addr`  out  AW  fetch word address.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid; one response per grant, in order.
- `mem_rdata`  in  DW  read data.
- `inst_valid`  out  1  queue head valid.
- `inst_ready`  in  1  decode accepts head.
- `inst`  out  DW  queue head instruction.
- `inst_pc`  out  AW  address the head instruction was fetched from.

## Operation
- FSM states:
  - IDLE: reset state; goes unconditionally to REQ on the first clock after reset release.
  - REQ: no request outstanding.
  - WAIT: one request granted, awaiting `mem_rvalid`.
  - FLUSH: outstanding response is to be discarded.
- At most one request is outstanding.
- Request outputs:
  - `mem_req = (state==REQ) && (count<2) && !br_taken`.
  - `mem_addr = pc`.
- Grant: `mem_req && mem_gnt` captures `pc` into `pend_pc` and moves REQ→WAIT.
- Response:
  - In WAIT, `mem_rvalid` pushes {`mem_rdata`, `pend_pc`} into the queue and moves WAIT→REQ.
  - In FLUSH, `mem_rvalid` drops the data and moves FLUSH→REQ.
- `inpc` selection, highest priority first:
  - `reset` low: 0.
  - `br_taken`: `br_target`.
  - grant this cycle: `pc+1`, wrapping modulo 2^AW (0xFFFFF→0x00000).
  - otherwise: `pc`.
- Queue: 2-entry FIFO with `count` 0..2.
  - `inst_valid = count!=0`. `inst`/`inst_pc` show the head.
  - Pop on `inst_valid && inst_ready`. Push and pop in the same cycle leave `count` unchanged.
  - Overflow is impossible: issue requires `count<2` and `count` cannot rise while a request is outstanding.
- Redirect (`br_taken`=1):
  - Queue cleared (`count`←0), overriding any same-cycle push or pop.
  - WAIT with no `mem_rvalid` this cycle → FLUSH.
  - WAIT with `mem_rvalid` this cycle → REQ; the data is discarded.
  - REQ → REQ; a pending ungranted request is withdrawn.
  - FLUSH stays FLUSH.
  - IDLE: ignored except for `inpc`.
- Ungranted request stability: `pc` is held through `inpc`, so `mem_addr` stays stable until grant or redirect.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, `count`=0, `pend_pc`=0, queue contents 0.
  - `inst_valid`=0, `inst`=0, `inst_pc`=0, `mem_req`=0, `inpc`=0.
- First `mem_req` is asserted in the 2nd cycle after reset deassertion (IDLE lasts one cycle).
- `mem_rvalid` arrives no earlier than the cycle after grant.
- Response to visibility: `inst_valid` rises the cycle after `mem_rvalid`.
- Best-case fetch: grant at cycle N, rvalid at N+1, inst_valid at N+2. Next request at N+2, so peak throughput is 1 instruction per 2 cycles.
- `pc` reflects `pc+1` the cycle after grant. `inpc` is combinational from `pc`, `br_taken`, `br_target`, `mem_gnt`, state and `count`.
- After `br_taken` at cycle N: `pc`=`br_target` and `inst_valid`=0 at N+1. The first request to the target is issued at N+1 if state is REQ, otherwise after the flushed response.
- Reset asserted mid-fetch abandons the outstanding request. The memory side must be reset in the same domain.

## Test plan
- Reset release with `mem_gnt`=1 and 1-cycle response latency, `inst_ready`=1, memory returning `rdata=0xA0000000|addr` → `mem_addr` 0,1,2,3 and `inst_pc` 0,1,2,3 in order, with `inst=0xA0000000|inst_pc`.
- `inst_ready`=0 after first fetch → exactly 2 entries queued, then `mem_req` stays 0 and `inpc==pc`. Raise `inst_ready` → entries drain in order and fetching resumes.
- `mem_gnt` held 0 for 5 cycles → `mem_req`=1 throughout, `mem_addr`/`pc` stable, `inpc==pc`.
- `br_taken`, `br_target=0x00100` while in WAIT with 2 queued → `inst_valid`=0 next cycle, late response dropped, next fetched `inst_pc`=0x00100. Repeat with `br_taken` in the same cycle as `mem_rvalid`: response dropped, state REQ.
- `pc`=0xFFFFF granted → `inpc`=0x00000, next `mem_addr`=0x00000, `inst_pc` of first entry 0xFFFFF.
- `reset` pulsed low while in WAIT with 1 queued → all outputs 0 immediately, and fetching restarts 2 cycles after release.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues single-outstanding word reads for the current PC,
// steers the PC register through inpc, and buffers fetched words in a 2-entry queue.
module fetch_unit #(
    parameter int AW = 20,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    output logic [AW-1:0] inpc,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst,
    output logic [AW-1:0] inst_pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FLUSH
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    count;
    logic [AW-1:0] pend_pc;
    logic [DW-1:0] q_inst [2];
    logic [AW-1:0] q_pc   [2];
    logic          rd_ptr, wr_ptr;
    logic          grant, push, pop;

    assign inst_valid = (count != 2'd0);
    assign inst       = q_inst[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];
    assign mem_addr   = pc;

    always_comb begin
        mem_req = (state == REQ) && (count < 2'd2) && !br_taken;
        grant   = mem_req && mem_gnt;
        // A redirect in the response cycle discards the returning word.
        push    = (state == WAIT) && mem_rvalid && !br_taken;
        pop     = inst_valid && inst_ready;
    end

    // The PC register has no enable, so "hold" means feeding pc straight back.
    always_comb begin
        if (!reset)
            inpc = '0;
        else if (br_taken)
            inpc = br_target;
        else if (grant)
            inpc = pc + AW'(1);
        else
            inpc = pc;
    end

    // NOTE: state_nxt is assigned before the case so every path has a value and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  state_nxt = REQ;
            REQ:   if (grant) state_nxt = WAIT;
            WAIT: begin
                if (mem_rvalid)
                    state_nxt = REQ;
                else if (br_taken)
                    state_nxt = FLUSH;
            end
            FLUSH: if (mem_rvalid) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pend_pc <= '0;
        end else begin
            state <= state_nxt;
            if (grant)
                pend_pc <= pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (br_taken) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage is reset because inst/inst_pc show the head even when empty and must read 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (push) begin
            q_inst[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]   <= pend_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC register and memory models, directed scenarios,
// and a randomized run scored against the expected program-order instruction stream.
module tb_fetch_unit;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam logic [DW-1:0] TAG = 32'hA000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] pc, inpc, br_target, mem_addr, inst_pc;
    logic          br_taken, mem_req, mem_gnt, mem_rvalid, inst_valid, inst_ready;
    logic [DW-1:0] mem_rdata, inst;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .inpc       (inpc),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc)
    );

    always #5 clk = ~clk;

    // PC register without enable, reset in the same domain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= '0;
        else        pc <= inpc;
    end

    // Memory model: gnt policy (0 always, 1 never, 2 random), latency (0 random 1..3, else fixed)
    int            gnt_mode = 0;
    int            lat_mode = 1;
    bit            pend_busy = 1'b0;
    int            pend_left = 0;
    logic [AW-1:0] pend_addr = '0;

    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (!reset) begin
                pend_busy = 1'b0;
                mem_gnt   = 1'b0;
            end else begin
                mem_gnt = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'b0 : ($urandom_range(0, 9) < 7);
                if (pend_busy) begin
                    pend_left--;
                    if (pend_left == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = TAG | 32'(pend_addr);
                        pend_busy  = 1'b0;
                    end
                end
            end
            #3;
            if (reset && mem_req && mem_gnt) begin
                pend_busy = 1'b1;
                pend_addr = mem_addr;
                pend_left = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
            end
        end
    end

    // Reference: decode must see consecutive addresses from the last redirect/reset, each tagged
    logic [AW-1:0] exp_pc = '0;
    int            pops = 0;

    initial begin
        forever begin
            @(posedge clk); #4;
            if (!reset) begin
                exp_pc = '0;
            end else begin
                if (inst_valid && inst_ready) begin
                    checks++;
                    if (inst_pc !== exp_pc || inst !== (TAG | 32'(exp_pc))) begin
                        errors++;
                        $display("FAIL sb_pop: inst_pc=%h inst=%h expected inst_pc=%h inst=%h",
                                 inst_pc, inst, exp_pc, TAG | 32'(exp_pc));
                    end
                    exp_pc = exp_pc + AW'(1);
                    pops++;
                end
                if (br_taken) exp_pc = br_target;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        reset = 1'b0; br_taken = 1'b0; inst_ready = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        br_taken = 1'b1; br_target = 20'h12345; inst_ready = 1'b1;
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({inst_valid, inst, inst_pc, mem_req, inpc} !== '0) begin
            errors++;
            $display("FAIL reset_async: valid=%b inst=%h inst_pc=%h req=%b inpc=%h, required all 0",
                     inst_valid, inst, inst_pc, mem_req, inpc);
        end
        tick(); #1;
        checks++;
        if ({inst_valid, inst, inst_pc, mem_req, inpc} !== '0) begin
            errors++;
            $display("FAIL reset_held: valid=%b inst=%h inst_pc=%h req=%b inpc=%h, required all 0",
                     inst_valid, inst, inst_pc, mem_req, inpc);
        end
    endtask

    task automatic test_basic_fetch();
        logic [AW-1:0] e;
        gnt_mode = 0; lat_mode = 1;
        do_reset();
        inst_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            #1;
            checks++;
            if (mem_req !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL basic_req c%0d: mem_req=%b required %b", i, mem_req, (i % 2 == 1));
            end
            if (i % 2 == 1) begin
                e = AW'((i - 1) / 2);
                checks++;
                if (mem_addr !== e || inpc !== e + AW'(1)) begin
                    errors++;
                    $display("FAIL basic_addr c%0d: mem_addr=%h inpc=%h required %h %h", i, mem_addr, inpc, e, e + AW'(1));
                end
            end
            checks++;
            if (inst_valid !== (i >= 3 && i % 2 == 1)) begin
                errors++;
                $display("FAIL basic_valid c%0d: inst_valid=%b required %b", i, inst_valid, (i >= 3 && i % 2 == 1));
            end
            if (i >= 3 && i % 2 == 1) begin
                e = AW'((i - 3) / 2);
                checks++;
                if (inst_pc !== e || inst !== (TAG | 32'(e))) begin
                    errors++;
                    $display("FAIL basic_inst c%0d: inst_pc=%h inst=%h required %h %h", i, inst_pc, inst, e, TAG | 32'(e));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        gnt_mode = 0; lat_mode = 1;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (pc !== 20'h2) begin
            errors++;
            $display("FAIL bp_pc: pc=%h required 00002", pc);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (mem_req !== 1'b0 || inpc !== pc || inst_valid !== 1'b1 || inst_pc !== 20'h0) begin
                errors++;
                $display("FAIL bp_full: req=%b inpc=%h pc=%h valid=%b inst_pc=%h required 0 pc pc 1 0",
                         mem_req, inpc, pc, inst_valid, inst_pc);
            end
            tick();
        end
        inst_ready = 1'b1;
        #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 20'h0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain0: valid=%b inst_pc=%h req=%b required 1 0 0", inst_valid, inst_pc, mem_req);
        end
        tick(); #1;
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 20'h1 || mem_req !== 1'b1 || mem_addr !== 20'h2) begin
            errors++;
            $display("FAIL bp_drain1: valid=%b inst_pc=%h req=%b addr=%h required 1 1 1 2",
                     inst_valid, inst_pc, mem_req, mem_addr);
        end
        tick(); #1;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: inst_valid=%b required 0", inst_valid);
        end
    endtask

    task automatic test_gnt_stall();
        gnt_mode = 1; lat_mode = 1;
        do_reset();
        inst_ready = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 20'h0 || pc !== 20'h0 || inpc !== pc) begin
                errors++;
                $display("FAIL stall_hold k%0d: req=%b addr=%h pc=%h inpc=%h required 1 0 0 0",
                         k, mem_req, mem_addr, pc, inpc);
            end
            if (k == 4) gnt_mode = 0;
            tick();
        end
        #1;
        checks++;
        if (!(mem_req && mem_gnt) || inpc !== 20'h1) begin
            errors++;
            $display("FAIL stall_grant: req=%b gnt=%b inpc=%h required 1 1 1", mem_req, mem_gnt, inpc);
        end
        tick(); #1;
        checks++;
        if (pc !== 20'h1) begin
            errors++;
            $display("FAIL stall_adv: pc=%h required 00001", pc);
        end
    endtask

    task automatic test_branch_wait();
        bit found = 1'b0;
        gnt_mode = 0; lat_mode = 3;
        do_reset();
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (inst_valid && pend_busy && !mem_rvalid) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL brw_setup: WAIT with queued entry not reached, valid=%b", inst_valid);
        end
        br_target = 20'h00100; br_taken = 1'b1;
        #1;
        checks++;
        if (inpc !== 20'h00100 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL brw_redirect: inpc=%h req=%b required 00100 0", inpc, mem_req);
        end
        tick();
        br_taken = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || pc !== 20'h00100) begin
            errors++;
            $display("FAIL brw_clear: valid=%b pc=%h required 0 00100", inst_valid, pc);
        end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick(); #1;
            checks++;
            if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL brw_flush: req=%b valid=%b required 0 0", mem_req, inst_valid);
            end
            if (mem_rvalid) found = 1'b1;
        end
        tick(); #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 20'h00100 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL brw_refetch: req=%b addr=%h valid=%b required 1 00100 0", mem_req, mem_addr, inst_valid);
        end
        inst_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(); #1;
            if (inst_valid) found = 1'b1;
        end
        checks++;
        if (!found || inst_pc !== 20'h00100) begin
            errors++;
            $display("FAIL brw_first: valid=%b inst_pc=%h required 1 00100", inst_valid, inst_pc);
        end
    endtask

    task automatic test_branch_rvalid();
        bit found = 1'b0;
        gnt_mode = 0; lat_mode = 2;
        do_reset();
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (inst_valid && mem_rvalid) found = 1'b1;
        end
        br_target = 20'h00200; br_taken = 1'b1;
        #1;
        checks++;
        if (!found || inpc !== 20'h00200 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL brr_redirect: setup=%b inpc=%h req=%b required 1 00200 0", found, inpc, mem_req);
        end
        tick();
        br_taken = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 20'h00200) begin
            errors++;
            $display("FAIL brr_drop: valid=%b req=%b addr=%h required 0 1 00200", inst_valid, mem_req, mem_addr);
        end
        inst_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(); #1;
            if (inst_valid) found = 1'b1;
        end
        checks++;
        if (!found || inst_pc !== 20'h00200) begin
            errors++;
            $display("FAIL brr_first: valid=%b inst_pc=%h required 1 00200", inst_valid, inst_pc);
        end
    endtask

    task automatic test_wrap();
        bit found = 1'b0;
        gnt_mode = 0; lat_mode = 1;
        do_reset();
        inst_ready = 1'b1;
        tick();
        br_target = 20'hFFFFF; br_taken = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL wrap_withdraw: mem_req=%b required 0", mem_req);
        end
        tick();
        br_taken = 1'b0;
        #1;
        checks++;
        if (!(mem_req && mem_gnt) || mem_addr !== 20'hFFFFF || inpc !== 20'h00000) begin
            errors++;
            $display("FAIL wrap_inc: req=%b gnt=%b addr=%h inpc=%h required 1 1 fffff 00000",
                     mem_req, mem_gnt, mem_addr, inpc);
        end
        for (int k = 0; k < 20 && !found; k++) begin
            tick(); #1;
            if (inst_valid) found = 1'b1;
        end
        checks++;
        if (!found || inst_pc !== 20'hFFFFF || inst !== (TAG | 32'hFFFFF) || !mem_req || mem_addr !== 20'h0) begin
            errors++;
            $display("FAIL wrap_next: valid=%b inst_pc=%h inst=%h req=%b addr=%h required 1 fffff a00fffff 1 00000",
                     inst_valid, inst_pc, inst, mem_req, mem_addr);
        end
    endtask

    task automatic test_reset_midfetch();
        bit found = 1'b0;
        gnt_mode = 0; lat_mode = 3;
        do_reset();
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (inst_valid && pend_busy) found = 1'b1;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (!found || {inst_valid, inst, inst_pc, mem_req, inpc} !== '0) begin
            errors++;
            $display("FAIL rst_mid: setup=%b valid=%b inst=%h inst_pc=%h req=%b inpc=%h required setup 1, rest 0",
                     found, inst_valid, inst, inst_pc, mem_req, inpc);
        end
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: req=%b valid=%b required 0 0", mem_req, inst_valid);
        end
        tick(); #1;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 20'h0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_restart: req=%b addr=%h valid=%b required 1 00000 0", mem_req, mem_addr, inst_valid);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] e;
        bit            prev_br = 1'b0;
        int            pops0;
        gnt_mode = 2; lat_mode = 0;
        do_reset();
        pops0 = pops;
        for (int c = 0; c < 3000; c++) begin
            tick();
            inst_ready = ($urandom_range(0, 3) != 0);
            if (!br_taken && $urandom_range(0, 29) == 0) begin
                br_taken  = 1'b1;
                br_target = ($urandom_range(0, 3) == 0) ? 20'hFFFFE : AW'($urandom);
            end else begin
                br_taken = 1'b0;
            end
            #1;
            e = br_taken ? br_target : (mem_req && mem_gnt) ? pc + AW'(1) : pc;
            checks++;
            if (inpc !== e) begin
                errors++;
                $display("FAIL rnd_inpc c%0d: inpc=%h required %h", c, inpc, e);
            end
            checks++;
            if (mem_req && (br_taken || pend_busy || mem_addr !== pc)) begin
                errors++;
                $display("FAIL rnd_req c%0d: req=%b br=%b outstanding=%b addr=%h pc=%h", c, mem_req, br_taken, pend_busy, mem_addr, pc);
            end
            if (prev_br) begin
                checks++;
                if (inst_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_brclr c%0d: inst_valid=%b required 0", c, inst_valid);
                end
            end
            prev_br = br_taken;
        end
        br_taken = 1'b0;
        tick();
        checks++;
        if (pops - pops0 < 100) begin
            errors++;
            $display("FAIL rnd_progress: %0d instructions delivered, required at least 100", pops - pops0);
        end
    endtask

    initial begin
        br_taken = 1'b0; br_target = '0; inst_ready = 1'b0;
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_gnt_stall();
        test_branch_wait();
        test_branch_rvalid();
        test_wrap();
        test_reset_midfetch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
